// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// State encoding is also what the debug state output reports.
package fetch_pkg;

    localparam int PC_W  = 16;
    localparam int CNT_W = 3;

    localparam logic [15:0] NOP_INSTR = 16'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/flush_counter.sv
// Bubble counter for redirect flushes: load / decrement / zero flag.
// Load has priority over decrement; the count saturates at zero.
module flush_counter
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and drives the synchronous instr_mem read port.
// Address is combinational from the PC register; valid lags the issued read by one cycle.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W         = fetch_pkg::PC_W,
    parameter int              ADDR_W       = 4,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              imem_rd_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              if_valid_o,
    output logic              flush_o,
    output logic [1:0]        state_o
);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
            $error("FLUSH_CYCLES must be in 1..7");
        end
        if (ADDR_W < 1 || ADDR_W > PC_W) begin : g_bad_addr_w
            $error("ADDR_W must be in 1..PC_W");
        end
    endgenerate

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic            if_valid, valid_nxt;
    logic            rd, flush, hold_valid;
    logic            take_redirect;
    logic            cnt_load, cnt_dec, cnt_zero;

    flush_counter u_flush_counter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (CNT_W'(FLUSH_CYCLES - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign take_redirect = redirect_i && (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        rd         = 1'b0;
        flush      = 1'b0;
        hold_valid = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                rd = 1'b1;
                if (halt_i && !take_redirect) begin
                    state_nxt = S_HALT;
                end else if (stall_i && !take_redirect) begin
                    hold_valid = 1'b1;
                end else if (!take_redirect) begin
                    pc_nxt = pc + PC_W'(1);
                end
            end
            S_FLUSH: begin
                // Stall and halt are deliberately ignored while bubbles drain.
                rd    = 1'b1;
                flush = 1'b1;
                if (!take_redirect) begin
                    pc_nxt = pc + PC_W'(1);
                    if (cnt_zero) begin
                        state_nxt = S_RUN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (resume_i && !take_redirect) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (take_redirect) begin
            flush     = 1'b1;
            pc_nxt    = redirect_pc_i;
            cnt_load  = 1'b1;
            state_nxt = S_FLUSH;
        end

        valid_nxt = hold_valid ? if_valid : (rd && !flush && (state != S_HALT));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            if_valid <= valid_nxt;
        end
    end

    assign imem_addr_o = pc[ADDR_W-1:0];
    assign imem_rd_o   = rd;
    assign pc_o        = pc;
    assign if_valid_o  = if_valid;
    assign flush_o     = flush;
    assign state_o     = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, scored per cycle against a reference model.
module tb_fetch_sequencer;

    localparam int FLUSH_CYCLES = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic        halt_i = 1'b0;
    logic        resume_i = 1'b0;
    logic [3:0]  imem_addr_o;
    logic        imem_rd_o;
    logic [15:0] pc_o;
    logic        if_valid_o;
    logic        flush_o;
    logic [1:0]  state_o;

    fetch_sequencer #(
        .PC_W         (16),
        .ADDR_W       (4),
        .RESET_PC     (16'd0),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .resume_i      (resume_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_o     (imem_rd_o),
        .pc_o          (pc_o),
        .if_valid_o    (if_valid_o),
        .flush_o       (flush_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  state;
        logic [15:0] pc;
        logic [3:0]  addr;
        logic        rd;
        logic        valid;
        logic        flush;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   checks = 0;
    int   failures = 0;

    // Reference model: mode, PC, remaining bubble cycles, and whether last cycle delivered a real fetch.
    int          m_mode;
    logic [15:0] m_pc;
    int          m_bubbles;
    logic        m_valid;
    logic [15:0] rnd_pc;

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_pc      = 16'd0;
        m_bubbles = 0;
        m_valid   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_pc"}, 32'(pc_o), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr_o), 32'd0);
        check({tag, "_rd"}, 32'(imem_rd_o), 32'd0);
        check({tag, "_valid"}, 32'(if_valid_o), 32'd0);
        check({tag, "_flush"}, 32'(flush_o), 32'd0);
    endtask

    // Drives one cycle of inputs, records what the DUT must present this cycle, advances the model.
    task automatic drive_cycle(input logic st, input logic rd, input logic hl, input logic rs,
                               input logic [15:0] rpc);
        obs_t e;
        logic redir, nv;
        stall_i       = st;
        redirect_i    = rd;
        halt_i        = hl;
        resume_i      = rs;
        redirect_pc_i = rpc;

        redir   = rd && (m_mode != M_IDLE);
        e.state = m_mode[1:0];
        e.pc    = m_pc;
        e.addr  = m_pc[3:0];
        e.rd    = (m_mode == M_RUN) || (m_mode == M_FLUSH);
        e.valid = m_valid;
        e.flush = (m_mode == M_FLUSH) || redir;
        exp_q.push_back(e);

        nv = e.rd && !e.flush && (m_mode != M_HALT);
        if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
        end else if (redir) begin
            m_pc      = rpc;
            m_bubbles = FLUSH_CYCLES;
            m_mode    = M_FLUSH;
        end else if (m_mode == M_RUN) begin
            if (hl) m_mode = M_HALT;
            else if (st) nv = m_valid;
            else m_pc = m_pc + 16'd1;
        end else if (m_mode == M_FLUSH) begin
            m_pc = m_pc + 16'd1;
            m_bubbles--;
            if (m_bubbles == 0) m_mode = M_RUN;
        end else if (rs) begin
            m_mode = M_RUN;
        end
        m_valid = nv;

        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a.state = state_o;
                mon_a.pc    = pc_o;
                mon_a.addr  = imem_addr_o;
                mon_a.rd    = imem_rd_o;
                mon_a.valid = if_valid_o;
                mon_a.flush = flush_o;
                checks++;
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL cycle_obs t=%0t state=%0d/%0d pc=%h/%h addr=%h/%h rd=%b/%b valid=%b/%b flush=%b/%b (actual/required)",
                             $time, mon_a.state, mon_e.state, mon_a.pc, mon_e.pc, mon_a.addr, mon_e.addr,
                             mon_a.rd, mon_e.rd, mon_a.valid, mon_e.valid, mon_a.flush, mon_e.flush);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Idle cycle, then sequential fetch of 0..4.
        repeat (6) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        check("pc_before_stall", 32'(pc_o), 32'd5);

        // Three stalled cycles at pc 5, then resume.
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        check("pc_after_stall", 32'(pc_o), 32'd5);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Redirect to 12 and drain the flush.
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'd12);
        check("redirect_target_pc", 32'(pc_o), 32'd12);
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Redirect, halt and stall together: redirect wins; target sits just below the wrap.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFD);
        check("simul_events_state", 32'(state_o), 32'd2);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        check("pc_wrap", 32'(pc_o), 32'd0);
        check("addr_wrap", 32'(imem_addr_o), 32'd0);
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Halt, three idle halted cycles, resume on the fourth.
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Asynchronous reset in the middle of a flush.
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040);
        redirect_i    = 1'b0;
        redirect_pc_i = 16'd0;
        check("pre_reset_flush", 32'(flush_o), 32'd1);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rnd_pc = 16'hFFF8 + 16'($urandom_range(0, 7));
            else rnd_pc = 16'($urandom);
            drive_cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 6,
                        $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 25, rnd_pc);
        end

        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
